// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the load/iterate/finish sequence controller.
// Holds the state encoding and the datapath select codes; the controller zero-extends these to SEL_W.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    RUN    = 2'b10,
    FINISH = 2'b11
  } state_t;

  localparam logic [2:0] SEL_IDLE = 3'd0;
  localparam logic [2:0] SEL_LOAD = 3'd1;
  localparam logic [2:0] SEL_RUN  = 3'd2;
  localparam logic [2:0] SEL_FIN  = 3'd5;

endpackage

// File: rtl/seq_step_counter.sv
// Iteration counter: clr has priority over en, and tc flags that cnt equals the terminal value TC.
// The next value appears one cycle after en or clr; it has no handshake and never stalls.
module seq_step_counter #(
  parameter int             CNT_W = 2,
  parameter logic [CNT_W-1:0] TC  = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == TC);

endmodule

// File: rtl/seq_controller.sv
// Moore controller: LOAD, then STEPS RUN cycles, then FINISH with a done pulse. Start is ignored while busy.
// Defining SEQ_CONTROLLER_ABORT_EN adds an abort input for LOAD/RUN and a one-cycle aborted flag.
module seq_controller
  import seq_ctrl_pkg::*;
#(
  parameter int STEPS = 4,
  parameter int SEL_W = 3,
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
`ifdef SEQ_CONTROLLER_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             e,
  output logic             m,
  output logic [SEL_W-1:0] sel,
  output logic [CNT_W-1:0] step,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic             mode_q;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             abort_hit;

`ifdef SEQ_CONTROLLER_ABORT_EN
  assign abort_hit = abort && ((state == LOAD) || (state == RUN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aborted <= 1'b0;
    end else begin
      aborted <= abort_hit;
    end
  end
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (tc) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mode_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) mode_q <= mode;
    end
  end

  // Held at zero outside RUN, so LOAD always enters RUN with step 0.
  seq_step_counter #(
    .CNT_W (CNT_W),
    .TC    (CNT_W'(STEPS - 1))
  ) u_step_counter (
    .clk   (clk),
    .reset (reset),
    .clr   ((state != RUN) || tc || abort_hit),
    .en    (state == RUN),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_comb begin
    sel = SEL_W'(SEL_IDLE);
    case (state)
      IDLE:    sel = SEL_W'(SEL_IDLE);
      LOAD:    sel = SEL_W'(SEL_LOAD);
      RUN:     sel = SEL_W'(SEL_RUN);
      FINISH:  sel = SEL_W'(SEL_FIN);
      default: sel = SEL_W'(SEL_IDLE);
    endcase
  end

  assign busy = (state != IDLE);
  assign e    = busy;
  assign done = (state == FINISH);
  assign m    = done && mode_q;
  assign step = (state == RUN) ? cnt : '0;

endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller: a STEPS=4/SEL_W=3 and a STEPS=1/SEL_W=4 instance share stimulus.
// Each is checked every cycle against a schedule model (position within the busy window).
module tb_seq_controller;

  logic clk = 1'b0;
  logic reset, start, mode;
`ifdef SEQ_CONTROLLER_ABORT_EN
  logic abort;
  logic aborted_a, aborted_b;
`endif

  logic       e_a, m_a, busy_a, done_a;
  logic [2:0] sel_a;
  logic [1:0] step_a;
  logic       e_b, m_b, busy_b, done_b;
  logic [3:0] sel_b;
  logic [0:0] step_b;

  int n_chk  = 0;
  int n_pass = 0;

  // pos: 0 = idle, 1 = LOAD, 2..steps+1 = RUN, steps+2 = FINISH
  int pos [2];
  int mq  [2];
  int ab  [2];

  always #5 clk = ~clk;

  seq_controller #(.STEPS(4), .SEL_W(3)) dut_a (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mode  (mode),
`ifdef SEQ_CONTROLLER_ABORT_EN
    .abort   (abort),
    .aborted (aborted_a),
`endif
    .e     (e_a),
    .m     (m_a),
    .sel   (sel_a),
    .step  (step_a),
    .busy  (busy_a),
    .done  (done_a)
  );

  seq_controller #(.STEPS(1), .SEL_W(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mode  (mode),
`ifdef SEQ_CONTROLLER_ABORT_EN
    .abort   (abort),
    .aborted (aborted_b),
`endif
    .e     (e_b),
    .m     (m_b),
    .sel   (sel_b),
    .step  (step_b),
    .busy  (busy_b),
    .done  (done_b)
  );

  function automatic int steps_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pos[i] = 0;
      mq[i]  = 0;
      ab[i]  = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int s;
      s = steps_of(i);
      ab[i] = 0;
      if (reset) begin
        pos[i] = 0;
        mq[i]  = 0;
      end else if (pos[i] == 0) begin
        if (start) begin
          pos[i] = 1;
          mq[i]  = int'(mode);
        end
`ifdef SEQ_CONTROLLER_ABORT_EN
      end else if (abort && pos[i] <= s + 1) begin
        pos[i] = 0;
        ab[i]  = 1;
`endif
      end else if (pos[i] == s + 2) begin
        pos[i] = 0;
      end else begin
        pos[i] = pos[i] + 1;
      end
    end
  endtask

  task automatic check_one(input string p, input int i, input int e_o, input int m_o,
                           input int sel_o, input int step_o, input int busy_o,
                           input int done_o, input int ab_o);
    int s, x_sel, x_step, x_fin;
    s      = steps_of(i);
    x_fin  = (pos[i] == s + 2) ? 1 : 0;
    x_sel  = (pos[i] == 0) ? 0 : (pos[i] == 1) ? 1 : (pos[i] <= s + 1) ? 2 : 5;
    x_step = (pos[i] >= 2 && pos[i] <= s + 1) ? pos[i] - 2 : 0;
    check({p, "_e"},    e_o,    (pos[i] != 0) ? 1 : 0);
    check({p, "_busy"}, busy_o, (pos[i] != 0) ? 1 : 0);
    check({p, "_sel"},  sel_o,  x_sel);
    check({p, "_step"}, step_o, x_step);
    check({p, "_done"}, done_o, x_fin);
    check({p, "_m"},    m_o,    x_fin * mq[i]);
`ifdef SEQ_CONTROLLER_ABORT_EN
    check({p, "_aborted"}, ab_o, ab[i]);
`else
    if (ab_o != 0) check({p, "_aborted"}, ab_o, 0);
`endif
  endtask

  task automatic check_all();
    int aa, abb;
`ifdef SEQ_CONTROLLER_ABORT_EN
    aa  = int'(aborted_a);
    abb = int'(aborted_b);
`else
    aa  = 0;
    abb = 0;
`endif
    check_one("a", 0, int'(e_a), int'(m_a), int'(sel_a), int'(step_a), int'(busy_a), int'(done_a), aa);
    check_one("b", 1, int'(e_b), int'(m_b), int'(sel_b), int'(step_b), int'(busy_b), int'(done_b), abb);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
`ifdef SEQ_CONTROLLER_ABORT_EN
    abort = 1'b0;
`endif
    model_reset();
    #1;
    check_all();
    cyc();
    cyc();
    reset = 1'b0;

    // single sequence, mode 0
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (9) cyc();

    // mode latched at start, then changed
    start = 1'b1;
    mode  = 1'b1;
    cyc();
    start = 1'b0;
    mode  = 1'b0;
    repeat (8) cyc();

    // start held high: back-to-back sequences with one idle gap
    start = 1'b1;
    mode  = 1'b1;
    repeat (20) cyc();
    start = 1'b0;
    repeat (8) cyc();

    // asynchronous reset mid-RUN (step 2 on instance a)
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    check("a_step_before_reset", int'(step_a), 2);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    cyc();
    reset = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (8) cyc();

`ifdef SEQ_CONTROLLER_ABORT_EN
    // abort at step 1
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (2) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    repeat (6) cyc();
`endif

    // randomized traffic
    repeat (3000) begin
      start = ($urandom_range(0, 3) == 0);
      mode  = 1'($urandom);
`ifdef SEQ_CONTROLLER_ABORT_EN
      abort = ($urandom_range(0, 7) == 0);
`endif
      reset = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (8) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
Name: seq_controller

Overview:
- Parametrised multi-cycle controller for a load/iterate/finish datapath; successor to the 4-state start/mode controller.
- On a start request it runs a LOAD cycle, then STEPS iterate cycles, then one FINISH cycle with a mode-dependent output and a one-cycle done pulse.
- Outputs drive datapath enable, mux select and mode bit.
- Adds a busy flag, a step index and a mode latched at start.

Parameters:
- STEPS, 4, number of RUN (iterate) cycles; legal range >= 1.
- SEL_W, 3, width of the datapath select bus; must be >= 3.
- CNT_W (localparam), $clog2(STEPS) with minimum 1, width of the step counter and step port.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a sequence; sampled only in IDLE.
- mode  input  1  finish-mode select; sampled on the IDLE->LOAD edge only.
- e  output  1  datapath register enable.
- m  output  1  finish-mode bit to the datapath (latched mode, FINISH only).
- sel  output  SEL_W  datapath mux select code.
- step  output  CNT_W  current iteration index during RUN, else 0.
- busy  output  1  high in LOAD, RUN and FINISH.
- done  output  1  one-cycle pulse in FINISH.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- On reset assertion (immediately, not waiting for clk):
  - state=IDLE, cnt=0, mode_q=0.
  - e=0, m=0, sel=0, step=0, busy=0, done=0.
- Output style: Moore. All outputs decode from registered state, cnt and mode_q; no combinational input-to-output path.
- States: 2-bit encoding, IDLE=00, LOAD=01, RUN=10, FINISH=11.
- IDLE:
  - Outputs: e=0, sel=SEL_IDLE(0), busy=0, done=0, m=0.
  - start=1 -> LOAD, mode_q<=mode, cnt<=0.
  - start=0 -> stay in IDLE.
- LOAD:
  - Outputs: e=1, sel=SEL_LOAD(1), busy=1.
  - Unconditionally -> RUN.
- RUN:
  - Outputs: e=1, sel=SEL_RUN(2), step=cnt, busy=1.
  - If cnt==STEPS-1 -> FINISH, cnt<=0.
  - Else cnt<=cnt+1 and stay in RUN.
- FINISH:
  - Outputs: e=1, sel=SEL_FIN(5), m=mode_q, done=1, busy=1.
  - Unconditionally -> IDLE.
- Latency: start sampled at edge k gives LOAD in cycle k+1, RUN in cycles k+2..k+1+STEPS, FINISH in k+2+STEPS, IDLE in k+3+STEPS. busy is high for exactly STEPS+2 cycles.
- start while busy is ignored, including start in FINISH. A new sequence needs start high in an IDLE cycle, so back-to-back sequences have a one-cycle IDLE gap.
- Changes on mode after the IDLE->LOAD edge have no effect on m.
- STEPS=1: RUN lasts one cycle with step=0.
- Reset mid-sequence aborts at once to IDLE; no done pulse is issued.
- Counter: no wrap is reachable, since cnt is cleared on the RUN->FINISH transition.
- sel constants are zero-extended to SEL_W.

Optional Feature:
- Macro: SEQ_CONTROLLER_ABORT_EN.
- When defined:
  - Adds input abort (1) and output aborted (1).
  - abort=1 in LOAD or RUN -> next state IDLE, cnt<=0, no FINISH, no done.
  - aborted pulses high for one cycle: the first IDLE cycle after the abort.
  - abort in IDLE or FINISH is ignored.
  - If abort and start are both high in IDLE, start wins.
- When undefined: neither port exists and behaviour is exactly as above.

Decomposition:
- Package seq_ctrl_pkg holds:
  - the state typedef (2-bit enum IDLE/LOAD/RUN/FINISH);
  - the select constants SEL_IDLE=0, SEL_LOAD=1, SEL_RUN=2, SEL_FIN=5.
- One natural sub-module, seq_step_counter:
  - parameter CNT_W, plus a terminal-count value;
  - inputs clr and en; outputs cnt and tc.

Test Plan:
- STEPS=4, mode=0, start pulse at cycle 0 -> busy cycles 1-6; sel 1,2,2,2,2,5; step 0,1,2,3 in cycles 2-5; done only in cycle 6, with m=0.
- mode=1 at start, then mode=0 from cycle 1 -> m=1 in FINISH.
- start held high continuously -> sequences repeat with busy low for exactly one cycle between done and the next LOAD; mid-sequence start has no effect.
- reset asserted asynchronously mid-RUN (step=2) -> all outputs 0 before the next clk edge; no done; the next start produces a normal full sequence.
- STEPS=1, SEL_W=4 build -> busy for 3 cycles, sel 1,2,5 zero-extended, step=0.
- With SEQ_CONTROLLER_ABORT_EN, abort at step=1 -> IDLE next cycle, aborted high one cycle, done never high.
